// File: rtl/cpu_bus_harness.sv
// cpu_bus_harness: bus-functional memory and run monitor for the cpu_top
// external bus. Mirrored RAM with preload, reset-vector override, read
// wait states via rdy, and pass/fail/timeout run status with counters.
module cpu_bus_harness #(
    parameter int                    ADDR_WIDTH   = 16,
    parameter int                    REG_WIDTH    = 8,
    parameter int                    MEM_DEPTH    = 4096,
    parameter int                    WAIT_STATES  = 0,
    parameter int                    MAX_CYCLES   = 30,
    parameter logic [ADDR_WIDTH-1:0] STATUS_ADDR  = 16'hFFF0,
    parameter logic [15:0]           RESET_VECTOR = 16'h0200
) (
    input  logic                         phi0,
    input  logic                         reset,
    input  logic [ADDR_WIDTH-1:0]        A,
    input  logic                         R_W_n,
    input  logic                         sync,
    input  logic [REG_WIDTH-1:0]         d_in,
    output logic [REG_WIDTH-1:0]         d_out,
    output logic                         d_oe,
    output logic                         rdy,
    input  logic                         load_en,
    input  logic [$clog2(MEM_DEPTH)-1:0] load_addr,
    input  logic [REG_WIDTH-1:0]         load_data,
    output logic                         done,
    output logic                         pass,
    output logic [REG_WIDTH-1:0]         fail_code,
    output logic                         timeout,
    output logic [31:0]                  cycle_count,
    output logic [31:0]                  instr_count
);

    localparam int IDX_W = $clog2(MEM_DEPTH);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_STALL = 1'b1;

    localparam logic [3:0]  WS_RELOAD   = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
    localparam logic [31:0] CYC_LAST    = 32'(MAX_CYCLES - 1);
    localparam logic [ADDR_WIDTH-1:0] VEC_LO = ADDR_WIDTH'(16'hFFFC);
    localparam logic [ADDR_WIDTH-1:0] VEC_HI = ADDR_WIDTH'(16'hFFFD);

    logic [REG_WIDTH-1:0] r_mem [MEM_DEPTH];

    logic [0:0]           r_state;
    logic [0:0]           w_state_nx;
    logic [3:0]           r_cnt;
    logic [3:0]           w_cnt_nx;
    logic                 w_rdy;
    logic                 w_wr;
    logic                 w_status_hit;
    logic                 w_expire;
    logic [IDX_W-1:0]     w_idx;

    logic                 r_done;
    logic                 r_pass;
    logic                 r_timeout;
    logic [REG_WIDTH-1:0] r_fail_code;
    logic [31:0]          r_cycle_count;
    logic [31:0]          r_instr_count;

    assign w_idx        = A[IDX_W-1:0];
    assign w_wr         = ~R_W_n & w_rdy;
    assign w_status_hit = w_wr & (A == STATUS_ADDR) & ~r_done;
    assign w_expire     = ~r_done & (r_cycle_count == CYC_LAST);

    // Asynchronous read path: vector bytes override the mirrored RAM.
    always_comb begin
        if (A == VEC_LO) begin
            d_out = REG_WIDTH'(RESET_VECTOR[7:0]);
        end else if (A == VEC_HI) begin
            d_out = REG_WIDTH'(RESET_VECTOR[15:8]);
        end else begin
            d_out = r_mem[w_idx];
        end
    end

    assign d_oe = R_W_n & ~reset;
    assign rdy  = w_rdy;

    // Wait-state sequencing; a preload cycle forces rdy low and freezes the FSM.
    always_comb begin
        w_rdy      = 1'b1;
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        if (load_en) begin
            w_rdy = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (R_W_n && (WAIT_STATES > 0)) begin
                        w_rdy      = 1'b0;
                        w_state_nx = ST_STALL;
                        w_cnt_nx   = WS_RELOAD;
                    end
                end
                ST_STALL: begin
                    if (r_cnt != 4'd0) begin
                        w_rdy    = 1'b0;
                        w_cnt_nx = r_cnt - 4'd1;
                    end else begin
                        w_state_nx = ST_IDLE;
                    end
                end
                default: begin
                    w_state_nx = ST_IDLE;
                end
            endcase
        end
    end

    // FSM state register; reset aborts any stall in progress.
    always_ff @(posedge phi0) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
        end
    end

    // RAM write port; preload has priority and RAM contents survive reset.
    always_ff @(posedge phi0) begin
        if (load_en) begin
            r_mem[load_addr] <= load_data;
        end else if (w_wr) begin
            r_mem[w_idx] <= d_in;
        end
    end

    // Run status: first status write wins, and beats a same-edge timeout.
    always_ff @(posedge phi0) begin
        if (reset) begin
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_timeout   <= 1'b0;
            r_fail_code <= '0;
        end else if (w_status_hit) begin
            r_done      <= 1'b1;
            r_fail_code <= d_in;
            r_pass      <= (d_in == '0);
        end else if (w_expire) begin
            r_done    <= 1'b1;
            r_timeout <= 1'b1;
        end
    end

    // Saturating cycle and instruction counters, frozen once the run is done.
    always_ff @(posedge phi0) begin
        if (reset) begin
            r_cycle_count <= '0;
            r_instr_count <= '0;
        end else if (!r_done) begin
            if (r_cycle_count != '1) begin
                r_cycle_count <= r_cycle_count + 32'd1;
            end
            if (sync && w_rdy && (r_instr_count != '1)) begin
                r_instr_count <= r_instr_count + 32'd1;
            end
        end
    end

    assign done        = r_done;
    assign pass        = r_pass;
    assign timeout     = r_timeout;
    assign fail_code   = r_fail_code;
    assign cycle_count = r_cycle_count;
    assign instr_count = r_instr_count;

endmodule

// File: doc/cpu_bus_harness.md
# cpu_bus_harness

Parametrised, synthesizable bus-functional memory and run monitor that attaches to the cpu_top external bus (A, D, R_W_n, sync, rdy) and replaces ad-hoc per-test stimulus. It provides mirrored RAM with a preload port, an overridden reset vector, and programmable read wait states driven through rdy. It also reports run status: pass/fail via a status-address write, instruction and cycle counts, and a cycle-budget timeout. It sits between the CPU and the top-level bench, or an FPGA debug wrapper.

## Interface
- ADDR_WIDTH, 16, CPU address width
- REG_WIDTH, 8, data width
- MEM_DEPTH, 4096, RAM words; power of two, ≤ 2^ADDR_WIDTH
- WAIT_STATES, 0, extra rdy-low cycles per read (0..15)
- MAX_CYCLES, 30, cycle budget before timeout (≥ 2)
- STATUS_ADDR, 16'hFFF0, write here ends the run
- RESET_VECTOR, 16'h0200, value returned at FFFC/FFFD
- phi0  in  1  clock, rising-edge
- reset  in  1  synchronous, active-high
- A  in  ADDR_WIDTH  CPU address
- R_W_n  in  1  1 = read, 0 = write
- sync  in  1  opcode-fetch cycle marker
- d_in  in  REG_WIDTH  CPU write data
- d_out  out  REG_WIDTH  read data to CPU
- d_oe  out  1  harness drives D
- rdy  out  1  access completes this cycle
- load_en  in  1  preload strobe
- load_addr  in  log2(MEM_DEPTH)  preload address
- load_data  in  REG_WIDTH  preload data
- done  out  1  run finished (status write or timeout)
- pass  out  1  status write of 0 received
- fail_code  out  REG_WIDTH  first status value written
- timeout  out  1  budget exhausted
- cycle_count  out  32  cycles since reset
- instr_count  out  32  completed sync cycles

## Operation
- Decode: RAM index = A[log2(MEM_DEPTH)-1:0]; higher bits are ignored, so RAM mirrors across the address space.
- Vector reads:
  - A == FFFC returns RESET_VECTOR[7:0].
  - A == FFFD returns RESET_VECTOR[15:8].
  - All other addresses, including FFFA/FFFB/FFFE/FFFF, read RAM.
- Reads are asynchronous. d_out = decoded data; d_oe = R_W_n & ~reset.
- Wait FSM, states IDLE and STALL, with 4-bit counter cnt:
  - IDLE, read, WAIT_STATES > 0: rdy = 0; go to STALL with cnt = WAIT_STATES-1.
  - IDLE, write, or WAIT_STATES = 0: rdy = 1.
  - STALL, cnt != 0: rdy = 0; cnt decrements.
  - STALL, cnt == 0: rdy = 1; return to IDLE.
  - Result: each read takes WAIT_STATES+1 cycles. Writes never stall.
- load_en overrides everything: rdy = 0 that cycle and the FSM holds its state.
- Write (R_W_n = 0, rdy = 1): mem[index] <= d_in at the edge.
- Preload: load_en writes mem[load_addr] <= load_data. It wins over any CPU write in the same cycle; the CPU write is not performed because rdy = 0.
- Status: a completed write to A == STATUS_ADDR while done = 0 sets done = 1, fail_code = d_in, pass = (d_in == 0). RAM is also written. Later status writes are ignored (first wins).
- Counters:
  - cycle_count increments every cycle while done = 0.
  - instr_count increments on cycles with sync = 1 & rdy = 1 & done = 0.
  - Both saturate rather than wrap.
- Timeout: when cycle_count == MAX_CYCLES-1 and it increments, timeout and done are set on the next cycle. pass stays 0.
- After done: counters freeze, status latches hold, CPU reads and writes continue normally.
- Reset:
  - Clears done, pass, timeout, fail_code, counters and cnt; FSM goes to IDLE.
  - RAM is not cleared, so preloads survive reset.
  - Reset in the middle of a STALL aborts it; the next cycle is evaluated from IDLE.

## Timing
- Reset values: done = 0, pass = 0, timeout = 0, fail_code = 0, cycle_count = 0, instr_count = 0, d_oe = 0. rdy follows the IDLE rule.
- Read latency: data is valid in the same cycle A is presented. rdy rises WAIT_STATES cycles later.
- Write and status: update is visible one cycle after the completing edge.
- Timeout: done first reads 1 in the cycle after cycle_count shows MAX_CYCLES-1; cycle_count then stays at MAX_CYCLES.
- Simultaneous status write and timeout edge: the status write wins, so timeout stays 0.

## Test plan
- Preload mem[0x0200] = A9, then read A = 0200 with WAIT_STATES = 0 -> d_out = A9, rdy = 1, d_oe = 1 in the same cycle.
- Read FFFC, then FFFD -> 00, then 02. Read 1200 with MEM_DEPTH = 4096 -> returns mem[0x200] (mirror).
- WAIT_STATES = 3, two back-to-back reads -> rdy pattern 0,0,0,1,0,0,0,1. Write during the run -> no stall.
- Write 00 to FFF0 -> done = 1, pass = 1, counters frozen. A later write of 5A to FFF0 leaves fail_code = 00.
- No status write, MAX_CYCLES = 30 -> timeout = done = 1 with cycle_count = 30 and pass = 0. A status write on the expiring edge -> timeout = 0, done via status.
- Assert reset during a STALL (WAIT_STATES = 5) -> FSM goes to IDLE and counters clear; preloaded RAM unchanged. load_en together with a CPU write -> load_data is stored and rdy = 0.
